// File: rtl/paint_pkg.sv
// Shared definitions for the paint pipeline: display geometry, the PS/2
// packet receiver state encoding and the bit positions inside a PS/2 mouse
// status byte (byte 0 of every movement packet).
package paint_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    WAIT_B0,  // expecting the status byte
    WAIT_B1,  // expecting the X movement byte
    WAIT_B2   // expecting the Y movement byte
  } ps2_state_t;

  // Status byte bit indices.
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int SYNC  = 3;  // always 1 in a genuine status byte
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;

endpackage

// File: rtl/axis_sat_add.sv
// Adds a signed delta to an unsigned screen coordinate and clamps the result
// to 0..max_pos. Purely combinational.
//   pos     : current coordinate (0..max_pos)
//   delta   : signed movement, DW bits wide
//   max_pos : largest legal coordinate
//   sat_pos : clamped new coordinate
// DW defaults to the 9-bit PS/2 delta; the Y instance uses 10 bits because it
// receives the negated delta, and -(-256) = +256 does not fit in 9 bits.
module axis_sat_add #(
  parameter int DW = 9
) (
  input  logic [9:0]          pos,
  input  logic signed [DW-1:0] delta,
  input  logic [9:0]          max_pos,
  output logic [9:0]          sat_pos
);

  // 12 bits signed holds 0..1023 plus/minus 512 without wrapping.
  logic signed [11:0] sum;

  assign sum = $signed({2'b00, pos}) + 12'(delta);

  always_comb begin
    sat_pos = sum[9:0];
    if (sum < 12'sd0) begin
      sat_pos = '0;
    end else if (sum > $signed({2'b00, max_pos})) begin
      sat_pos = max_pos;
    end
  end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Assembles 3-byte PS/2 mouse movement packets from the byte receiver and
// keeps the cursor position (saturated to the display) plus button levels
// for the colour mapper.
//   Clk        : system clock
//   Reset      : synchronous active-high reset
//   byte_valid : one-cycle strobe, byte_data holds a new PS/2 byte
//   byte_data  : received byte
//   BallX      : cursor X, 0..X_MAX
//   BallY      : cursor Y, 0..Y_MAX
//   left_btn   : left button from the last applied packet
//   right_btn  : right button from the last applied packet
//   pkt_strobe : one-cycle pulse, a packet was applied
//   sync_err   : one-cycle pulse, a byte was discarded or a packet abandoned
module mouse_cursor_tracker
  import paint_pkg::*;
#(
  parameter int X_MAX   = SCREEN_W - 1,
  parameter int Y_MAX   = SCREEN_H - 1,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic       left_btn,
  output logic       right_btn,
  output logic       pkt_strobe,
  output logic       sync_err
);

  localparam int CW = $clog2(TIMEOUT);

  ps2_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] status_q, status_d;
  logic [7:0] dx_q, dx_d;
  logic       apply, err;

  logic signed [8:0] dx, dy;
  logic signed [9:0] dy_neg;
  logic [9:0] x_next, y_next;

  // Deltas for the packet being completed: dy comes straight from the byte
  // arriving in WAIT_B2, so both are valid in the apply cycle.
  assign dx     = status_q[XOVF] ? 9'sd0 : $signed({status_q[XSIGN], dx_q});
  assign dy     = status_q[YOVF] ? 9'sd0 : $signed({status_q[YSIGN], byte_data});
  assign dy_neg = -10'(dy);  // PS/2 Y grows upward, screen Y grows downward

  axis_sat_add #(.DW(9)) u_x_add (
    .pos    (BallX),
    .delta  (dx),
    .max_pos(10'(X_MAX)),
    .sat_pos(x_next)
  );

  axis_sat_add #(.DW(10)) u_y_add (
    .pos    (BallY),
    .delta  (dy_neg),
    .max_pos(10'(Y_MAX)),
    .sat_pos(y_next)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    dx_d     = dx_q;
    apply    = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      WAIT_B0: begin
        cnt_d = '0;
        if (byte_valid) begin
          if (byte_data[SYNC]) begin
            status_d = byte_data;
            state_d  = WAIT_B1;
          end else begin
            err = 1'b1;  // out-of-sync byte: drop and keep hunting
          end
        end
      end
      WAIT_B1, WAIT_B2: begin
        if (byte_valid) begin
          // An arriving byte wins over a simultaneous timeout expiry.
          cnt_d = '0;
          if (state_q == WAIT_B1) begin
            dx_d    = byte_data;
            state_d = WAIT_B2;
          end else begin
            apply   = 1'b1;
            state_d = WAIT_B0;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          err     = 1'b1;
          state_d = WAIT_B0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_B0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= WAIT_B0;
      cnt_q      <= '0;
      status_q   <= '0;
      dx_q       <= '0;
      BallX      <= 10'(X_INIT);
      BallY      <= 10'(Y_INIT);
      left_btn   <= 1'b0;
      right_btn  <= 1'b0;
      pkt_strobe <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      status_q   <= status_d;
      dx_q       <= dx_d;
      pkt_strobe <= apply;
      sync_err   <= err;
      if (apply) begin
        BallX     <= x_next;
        BallY     <= y_next;
        left_btn  <= status_q[BTN_L];
        right_btn <= status_q[BTN_R];
      end
    end
  end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed bench for mouse_cursor_tracker. Inputs change and outputs are
// sampled on the falling edge; the design acts on the rising edge.
module tb_mouse_cursor_tracker;

  localparam int TO = 40;  // short timeout keeps the run brief

  logic       Clk = 1'b0;
  logic       Reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [9:0] BallX, BallY;
  logic       left_btn, right_btn, pkt_strobe, sync_err;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mouse_cursor_tracker #(
    .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240), .TIMEOUT(TO)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .BallX     (BallX),
    .BallY     (BallY),
    .left_btn  (left_btn),
    .right_btn (right_btn),
    .pkt_strobe(pkt_strobe),
    .sync_err  (sync_err)
  );

  // Present one byte for exactly one rising edge; returns on the falling edge
  // right after the edge that consumed it.
  task automatic send_byte(input logic [7:0] b);
    @(negedge Clk);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge Clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic test_reset;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    checks++;
    if (BallX !== 10'd320 || BallY !== 10'd240) begin
      errors++;
      $display("FAIL reset_pos: got (%0d,%0d) want (320,240)", BallX, BallY);
    end
    checks++;
    if ({left_btn, right_btn, pkt_strobe, sync_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {left_btn, right_btn, pkt_strobe, sync_err});
    end
  endtask

  task automatic test_basic;
    send_pkt(8'h08, 8'h0A, 8'h05);  // dx=+10, dy=+5 (up)
    checks++;
    if (pkt_strobe !== 1'b1) begin
      errors++;
      $display("FAIL basic_strobe: got %b want 1", pkt_strobe);
    end
    checks++;
    if (BallX !== 10'd330 || BallY !== 10'd235 || left_btn !== 1'b0) begin
      errors++;
      $display("FAIL basic_pos: got (%0d,%0d,L=%b) want (330,235,L=0)", BallX, BallY, left_btn);
    end
    @(negedge Clk);
    checks++;
    if (pkt_strobe !== 1'b0) begin
      errors++;
      $display("FAIL basic_strobe_width: got %b want 0", pkt_strobe);
    end
  endtask

  task automatic test_clamp_x;
    send_pkt(8'h18, 8'h01, 8'h00);  // dx=-255 -> 75
    send_pkt(8'h18, 8'hBA, 8'h00);  // dx=-70  -> 5
    checks++;
    if (BallX !== 10'd5) begin
      errors++;
      $display("FAIL setup_x5: got %0d want 5", BallX);
    end
    send_pkt(8'h19, 8'hF0, 8'h00);  // dx=-16, left pressed
    checks++;
    if (BallX !== 10'd0 || BallY !== 10'd235 || left_btn !== 1'b1) begin
      errors++;
      $display("FAIL clamp_x_low: got (%0d,%0d,L=%b) want (0,235,L=1)", BallX, BallY, left_btn);
    end
  endtask

  task automatic test_clamp_y;
    send_pkt(8'h28, 8'h00, 8'h18);  // dy=-232 -> Y=467
    send_pkt(8'h08, 8'h00, 8'hF8);  // dy=-8  (YSIGN clear -> +248)? no: see below
    // 0x08 status with dy byte 0xF8 is dy=+248 -> Y=219; go back down.
    send_pkt(8'h28, 8'h00, 8'h00);  // dy=-256 -> Y=475
    checks++;
    if (BallY !== 10'd475) begin
      errors++;
      $display("FAIL setup_y475: got %0d want 475", BallY);
    end
    send_pkt(8'h28, 8'h00, 8'hF6);  // dy=-10 -> 485 clamped
    checks++;
    if (BallY !== 10'd479) begin
      errors++;
      $display("FAIL clamp_y_high: got %0d want 479", BallY);
    end
    send_pkt(8'h08, 8'h00, 8'h0A);  // dy=+10 -> 469
    checks++;
    if (BallY !== 10'd469 || left_btn !== 1'b0) begin
      errors++;
      $display("FAIL y_up: got (%0d,L=%b) want (469,L=0)", BallY, left_btn);
    end
  endtask

  task automatic test_sync_discard;
    send_byte(8'h00);
    checks++;
    if (sync_err !== 1'b1 || pkt_strobe !== 1'b0) begin
      errors++;
      $display("FAIL sync_discard: got err=%b strobe=%b want err=1 strobe=0", sync_err, pkt_strobe);
    end
    send_pkt(8'h08, 8'h01, 8'h00);
    checks++;
    if (BallX !== 10'd1 || BallY !== 10'd469 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL sync_resume: got (%0d,%0d,err=%b) want (1,469,err=0)", BallX, BallY, sync_err);
    end
  endtask

  task automatic test_timeout;
    int n;
    bit seen, strobe_seen;
    send_byte(8'h08);
    send_byte(8'h05);  // dx byte; counter restarts on this edge
    n = 0;
    seen = 1'b0;
    strobe_seen = 1'b0;
    while (!seen && n < 3 * TO) begin
      @(posedge Clk);
      #1;
      n++;
      if (pkt_strobe) strobe_seen = 1'b1;
      if (sync_err) seen = 1'b1;
    end
    checks++;
    if (!seen || n != TO) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles (seen=%b) want %0d", n, seen, TO);
    end
    checks++;
    if (strobe_seen || BallX !== 10'd1 || BallY !== 10'd469) begin
      errors++;
      $display("FAIL timeout_outputs: got (%0d,%0d,strobe=%b) want (1,469,strobe=0)", BallX, BallY, strobe_seen);
    end
    send_pkt(8'h08, 8'h03, 8'h00);
    checks++;
    if (BallX !== 10'd4 || BallY !== 10'd469 || pkt_strobe !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover: got (%0d,%0d,strobe=%b) want (4,469,1)", BallX, BallY, pkt_strobe);
    end
  endtask

  task automatic test_overflow;
    send_pkt(8'hC9, 8'h7F, 8'h7F);
    checks++;
    if (BallX !== 10'd4 || BallY !== 10'd469 || left_btn !== 1'b1 || pkt_strobe !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got (%0d,%0d,L=%b,strobe=%b) want (4,469,L=1,strobe=1)",
               BallX, BallY, left_btn, pkt_strobe);
    end
  endtask

  task automatic test_back_to_back;
    send_pkt(8'h0A, 8'h02, 8'h00);  // right pressed, dx=+2
    checks++;
    if (BallX !== 10'd6 || right_btn !== 1'b1 || left_btn !== 1'b0 || pkt_strobe !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got (%0d,L=%b,R=%b,strobe=%b) want (6,0,1,1)", BallX, left_btn, right_btn, pkt_strobe);
    end
    send_pkt(8'h08, 8'h02, 8'h00);
    checks++;
    if (BallX !== 10'd8 || right_btn !== 1'b0 || pkt_strobe !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got (%0d,R=%b,strobe=%b) want (8,0,1)", BallX, right_btn, pkt_strobe);
    end
  endtask

  task automatic test_reset_mid_packet;
    send_pkt(8'h09, 8'h00, 8'h00);  // make left_btn=1 before the reset
    send_byte(8'h08);
    send_byte(8'h05);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checks++;
    if (BallX !== 10'd320 || BallY !== 10'd240 || left_btn !== 1'b0 || pkt_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got (%0d,%0d,L=%b,strobe=%b) want (320,240,0,0)", BallX, BallY, left_btn, pkt_strobe);
    end
    // A stale WAIT_B2 would take this as dy; from WAIT_B0 it is a bad sync byte.
    send_byte(8'h07);
    checks++;
    if (pkt_strobe !== 1'b0 || sync_err !== 1'b1 || BallY !== 10'd240) begin
      errors++;
      $display("FAIL reset_mid_state: got (strobe=%b,err=%b,Y=%0d) want (0,1,240)", pkt_strobe, sync_err, BallY);
    end
  endtask

  initial begin
    Reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    test_reset();
    test_basic();
    test_clamp_x();
    test_clamp_y();
    test_sync_discard();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouse_cursor_tracker.md
Name: mouse_cursor_tracker

Overview:
- Upstream of the colour mapper.
- Consumes PS/2 mouse bytes from the existing PS/2 byte receiver and assembles standard 3-byte movement packets.
- Maintains the on-screen cursor position, saturated to the display area.
- Drives the cursor coordinates (BallX, BallY) and the left-button level that the colour mapper uses for palette/tool selection and canvas painting.

Parameters:
- X_MAX, 639, largest legal cursor X (display width - 1)
- Y_MAX, 479, largest legal cursor Y (display height - 1)
- X_INIT, 320, cursor X after reset
- Y_INIT, 240, cursor Y after reset
- TIMEOUT, 2_000_000, inter-byte gap in Clk cycles (~40 ms at 50 MHz) after which a partial packet is abandoned

Ports:
- Clk  input  1  system clock, single clock domain
- Reset  input  1  synchronous, active-high reset
- byte_valid  input  1  one-cycle strobe: byte_data holds a new received PS/2 byte
- byte_data  input  8  received byte
- BallX  output  10  cursor X, 0..X_MAX
- BallY  output  10  cursor Y, 0..Y_MAX
- left_btn  output  1  left button level from the last accepted packet
- right_btn  output  1  right button level from the last accepted packet
- pkt_strobe  output  1  one-cycle pulse: a packet was applied
- sync_err  output  1  one-cycle pulse: a byte was discarded or a packet was abandoned

Behaviour:
- Interface: one clock, Clk; Reset is synchronous and active-high. Reset has priority over all other inputs.
- Reset values:
  - BallX = X_INIT, BallY = Y_INIT
  - left_btn = 0, right_btn = 0, pkt_strobe = 0, sync_err = 0
  - state = WAIT_B0, timeout counter = 0
- FSM states: WAIT_B0, WAIT_B1, WAIT_B2.
- WAIT_B0, byte_valid:
  - byte_data[3] = 1: latch as status byte, go to WAIT_B1.
  - byte_data[3] = 0: discard the byte, pulse sync_err, stay in WAIT_B0.
- WAIT_B1, byte_valid: latch dx byte, go to WAIT_B2.
- WAIT_B2, byte_valid: use the byte as dy, apply the packet (below), go to WAIT_B0.
- Timeout:
  - The counter clears on every accepted byte and counts only in WAIT_B1/WAIT_B2.
  - Reaching TIMEOUT-1 with no byte_valid: go to WAIT_B0, pulse sync_err, leave all outputs unchanged.
  - byte_valid in the expiry cycle: the byte is accepted and the timeout is ignored.
- Packet apply (registered on the edge that accepts byte 2; visible 1 cycle later; pkt_strobe high that same cycle):
  - dx = signed 9-bit {status[4], dx_byte}; dy = signed 9-bit {status[5], dy_byte}.
  - status[6] (X overflow) = 1 forces dx = 0; status[7] (Y overflow) = 1 forces dy = 0.
  - Next X = BallX + dx, computed in 12-bit signed; < 0 gives 0, > X_MAX gives X_MAX.
  - Next Y = BallY - dy (PS/2 Y is positive-up; screen Y is down); same clamp to 0..Y_MAX.
  - left_btn <= status[0]; right_btn <= status[1]. Buttons update even when an overflow bit forces a delta to 0.
- Outputs change only on packet apply or Reset; they are stable between packets. No glitches, all outputs registered.
- Reset mid-packet: the partial packet is dropped, no pkt_strobe, outputs return to reset values.

Decomposition:
- Shared package paint_pkg holds:
  - SCREEN_W = 640, SCREEN_H = 480
  - typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} ps2_state_t
  - status bit index constants: BTN_L = 0, BTN_R = 1, SYNC = 3, XSIGN = 4, YSIGN = 5, XOVF = 6, YOVF = 7
- One sub-module, axis_sat_add: combinational; inputs 10-bit position, 9-bit signed delta, 10-bit max; output clamped 10-bit position. Instantiated twice (Y instance fed the negated dy).

Test Plan:
- Reset, then packet 0x08,0x0A,0x05 -> BallX=330, BallY=235, left_btn=0, pkt_strobe one cycle after the 3rd byte.
- From X=5, packet 0x19,0xF0,0x00 (dx=-16, left pressed) -> BallX=0 (clamped), left_btn=1, BallY unchanged.
- From Y=475, packet 0x28,0x00,0xF6 (dy=-10) -> BallY=479 (clamped); then packet 0x08,0x00,0x0A -> BallY=469.
- Byte 0x00 in WAIT_B0 -> sync_err pulse, no state change; following 0x08,0x01,0x00 -> BallX+1.
- Send 0x08,0x05, then idle TIMEOUT cycles -> sync_err pulse, return to WAIT_B0; next full packet applies correctly with no stale dx.
- Packet 0xC9,0x7F,0x7F (both overflow, left) -> position unchanged, left_btn=1, pkt_strobe pulses; Reset asserted between bytes 1 and 2 -> reset values restored, no strobe.
